// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative integer divider.
package div_unit_pkg;

    localparam int XLEN       = 32;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    typedef logic [XLEN-1:0] data_bus_t;

    localparam data_bus_t INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        DIV_  = 2'd0,
        DIVU_ = 2'd1,
        REM_  = 2'd2,
        REMU_ = 2'd3
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREPARE = 3'd1,
        DIVIDE  = 3'd2,
        RESTORE = 3'd3,
        DONE    = 3'd4
    } div_fsm_e;

    // Signed opcodes need absolute values in and sign fix-up out.
    function automatic logic is_signed_op(input div_ops_e op);
        return (op == DIV_) || (op == REM_);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Operand/result handshake between the execute stage and the divider.
interface div_unit_if;
    import div_unit_pkg::*;

    data_bus_t dividend_i;
    data_bus_t divisor_i;
    div_ops_e  opcode_i;
    logic      data_valid_i;
    logic      clear_i;

    data_bus_t result_o;
    logic      data_valid_o;
    logic      divide_by_zero_o;
    logic      overflow_o;
    fu_state_e div_unit_state_o;

    modport master (
        output dividend_i, divisor_i, opcode_i, data_valid_i, clear_i,
        input  result_o, data_valid_o, divide_by_zero_o, overflow_o, div_unit_state_o
    );

    modport slave (
        input  dividend_i, divisor_i, opcode_i, data_valid_i, clear_i,
        output result_o, data_valid_o, divide_by_zero_o, overflow_o, div_unit_state_o
    );

endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step
    import div_unit_pkg::*;
(
    input  logic [XLEN:0] rem_i,
    input  data_bus_t     quo_i,
    input  data_bus_t     divisor_i,
    output logic [XLEN:0] rem_o,
    output data_bus_t     quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    // Trial subtraction; keep the difference only when it does not go negative.
    always_comb begin
        // NOTE: every output gets a value on every path so no latch is inferred.
        shifted = {rem_i, quo_i[XLEN-1]};
        fits    = (shifted >= {2'b00, divisor_i});
        diff    = shifted[XLEN:0] - {1'b0, divisor_i};
        rem_o   = fits ? diff : shifted[XLEN:0];
        quo_o   = {quo_i[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU with RISC-V special cases.
module div_unit
    import div_unit_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    div_unit_if.slave bus
);

    div_fsm_e        state_q;
    div_ops_e        op_q;
    data_bus_t       dividend_q;
    data_bus_t       divisor_q;
    data_bus_t       quo_q;
    logic [XLEN:0]   rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            dbz_pend_q;
    logic            ovf_pend_q;
    data_bus_t       result_q;
    logic            valid_q;
    logic            dbz_q;
    logic            ovf_q;

    logic [XLEN:0]   rem_d;
    data_bus_t       quo_d;
    logic            signed_op;
    data_bus_t       dividend_abs;
    data_bus_t       divisor_abs;
    logic            unit_free;
    logic            accept;

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    // Operand conditioning for the signed ops and the accept decision.
    always_comb begin
        signed_op    = is_signed_op(op_q);
        dividend_abs = (signed_op && dividend_q[XLEN-1]) ? -dividend_q : dividend_q;
        divisor_abs  = (signed_op && divisor_q[XLEN-1])  ? -divisor_q  : divisor_q;
        unit_free    = (state_q == IDLE) || (state_q == DONE);
        accept       = unit_free && bus.data_valid_i && !bus.clear_i;
    end

    // Divider FSM with registered result, flags and valid pulse.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
        if (!rst_n_i) begin
            // NOTE: there is no storage array here, so every register gets a defined reset value.
            state_q    <= IDLE;
            op_q       <= DIV_;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.clear_i) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    PREPARE: begin
                        q_neg_q <= 1'b0;
                        r_neg_q <= 1'b0;
                        if (divisor_q == '0) begin
                            quo_q      <= '1;
                            rem_q      <= {1'b0, dividend_q};
                            dbz_pend_q <= 1'b1;
                            state_q    <= DONE;
                        end else if (signed_op && (dividend_q == INT_MIN) && (divisor_q == '1)) begin
                            quo_q      <= INT_MIN;
                            rem_q      <= '0;
                            ovf_pend_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            q_neg_q   <= signed_op && (dividend_q[XLEN-1] ^ divisor_q[XLEN-1]);
                            r_neg_q   <= signed_op && dividend_q[XLEN-1];
                            quo_q     <= dividend_abs;
                            divisor_q <= divisor_abs;
                            rem_q     <= '0;
                            cnt_q     <= CNT_W'(DIV_CYCLES - 1);
                            state_q   <= DIVIDE;
                        end
                    end
                    DIVIDE: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= RESTORE;
                        end
                    end
                    RESTORE: begin
                        if (q_neg_q) begin
                            quo_q <= -quo_q;
                        end
                        if (r_neg_q) begin
                            rem_q <= {1'b0, -rem_q[XLEN-1:0]};
                        end
                        state_q <= DONE;
                    end
                    DONE: begin
                        result_q <= ((op_q == DIV_) || (op_q == DIVU_)) ? quo_q : rem_q[XLEN-1:0];
                        valid_q  <= 1'b1;
                        dbz_q    <= dbz_pend_q;
                        ovf_q    <= ovf_pend_q;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase

                // A new operation may start from IDLE or in the DONE cycle (back-to-back).
                if (accept) begin
                    op_q       <= bus.opcode_i;
                    dividend_q <= bus.dividend_i;
                    divisor_q  <= bus.divisor_i;
                    dbz_pend_q <= 1'b0;
                    ovf_pend_q <= 1'b0;
                    state_q    <= PREPARE;
                    if (state_q == IDLE) begin
                        dbz_q <= 1'b0;
                        ovf_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.result_o         = result_q;
    assign bus.data_valid_o     = valid_q;
    assign bus.divide_by_zero_o = dbz_q;
    assign bus.overflow_o       = ovf_q;
    assign bus.div_unit_state_o = unit_free ? FREE : BUSY;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider for the M extension; it executes DIV, DIVU, REM and REMU.
- It pairs with the multiplier and sits in the execute stage beside the ALU.
- It takes operands and a div_ops_e opcode through a valid/busy handshake and returns one result with a valid pulse.
- Radix-2 restoring algorithm, one quotient bit per clock, with RISC-V special-case semantics.

Parameters:
- XLEN, 32, operand/result width (package constant, not overridden per instance)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- dividend_i  in  XLEN  rs1 operand (data_bus_t)
- divisor_i  in  XLEN  rs2 operand (data_bus_t)
- opcode_i  in  2  div_ops_e: DIV_, DIVU_, REM_, REMU_
- data_valid_i  in  1  operand strobe; accepted only when unit FREE
- clear_i  in  1  pipeline flush; aborts the in-flight operation
- result_o  out  XLEN  quotient or remainder (data_bus_t)
- data_valid_o  out  1  one-cycle pulse, result_o valid
- divide_by_zero_o  out  1  qualified by data_valid_o
- overflow_o  out  1  signed overflow flag, qualified by data_valid_o
- div_unit_state_o  out  1  fu_state_e, FREE/BUSY

Behaviour:
- Reset is synchronous, active-low, clk_i only. After reset: state IDLE; result_o=0; data_valid_o=0; flags=0; div_unit_state_o=FREE.
- FSM states: IDLE, PREPARE, DIVIDE, RESTORE, DONE.
- IDLE:
  - data_valid_i=1 latches operands and opcode, then goes to PREPARE. div_unit_state_o=BUSY from the next cycle.
  - While BUSY, data_valid_i is ignored (no queueing).
- PREPARE (1 cycle):
  - Signed ops (DIV_, REM_): take absolute values and record quotient sign = sign(dividend) xor sign(divisor), remainder sign = sign(dividend).
  - Divisor==0: go to DONE. Quotient = all ones, remainder = dividend, divide_by_zero_o=1.
  - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF: go to DONE. Quotient = 0x80000000, remainder = 0, overflow_o=1.
  - Otherwise: clear the 33-bit partial remainder, load the counter with 31, go to DIVIDE.
- DIVIDE (32 cycles):
  - Each cycle: shift {rem, quo} left by 1, trial subtract divisor.
  - Result non-negative: keep the difference, quotient LSB=1. Otherwise restore, LSB=0.
  - counter==0 moves to RESTORE.
- RESTORE (1 cycle): apply two's-complement negation to quotient/remainder per the recorded signs; signed ops only.
- DONE (1 cycle):
  - Outputs: result_o = quotient for DIV_/DIVU_, remainder for REM_/REMU_; data_valid_o=1; state returns to IDLE.
  - div_unit_state_o=FREE in this cycle, so a new data_valid_i here is accepted (back-to-back).
- Latency from the accept edge to the data_valid_o cycle: normal 35 cycles (PREPARE 1 + DIVIDE 32 + RESTORE 1 + DONE 1); special cases 2 cycles.
- result_o and the flags hold their last value until the next DONE. Flags clear on each new accept.
- clear_i:
  - In any non-IDLE state, go to IDLE next cycle with no data_valid_o.
  - clear_i and data_valid_i together in IDLE: clear wins, nothing accepted.
- Reset mid-operation: same as the reset values; no valid pulse.
- DIVU_/REMU_ treat operands as unsigned; 0x80000000/0xFFFFFFFF is not overflow for them.

Decomposition:
- div_ops_e, fu_state_e, data_bus_t and XLEN already live in MGT_01_PACKAGE; reuse them.
- Add to the package: div_fsm_e (IDLE, PREPARE, DIVIDE, RESTORE, DONE) and the constant DIV_CYCLES=32.
- One natural sub-module: div_step. It is combinational, one restoring iteration: inputs {rem, quo}, divisor; outputs the next {rem, quo}. It can be unrolled later for radix-4.

Test Plan:
1. DIV_ 100/7 gives result_o=14 at exactly 35 cycles after accept. REM_ 100/7 gives 2. Flags 0.
2. Signed operands:
   - DIV_ 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3).
   - REM_ same operands -> 0xFFFFFFFF(-1).
   - DIV_ 7/0xFFFFFFFE -> 0xFFFFFFFD.
   - DIVU_ 0xFFFFFFFF/2 -> 0x7FFFFFFF.
3. Divide by zero:
   - DIV_ 5/0 -> 0xFFFFFFFF, divide_by_zero_o=1, 2-cycle latency.
   - REMU_ 5/0 -> 5.
4. Overflow:
   - DIV_ 0x80000000/0xFFFFFFFF -> 0x80000000, overflow_o=1.
   - REM_ same operands -> 0.
   - DIVU_ same operands -> 0, flags 0.
5. Handshake:
   - data_valid_i held during BUSY -> only one operation executes.
   - New op issued in the DONE cycle -> accepted, next result 35 cycles later.
6. Abort:
   - clear_i at DIVIDE cycle 10 -> IDLE, FREE next cycle, no data_valid_o.
   - rst_n_i=0 mid-DIVIDE -> all outputs reset values on the next edge.
